// File: rtl/alu_if.sv
// Operand/control bundle for the WideWord SIMD ALU.
// master drives operands and controls; slave (the ALU) returns the registered result.
interface alu_if;
  logic [0:127] reg_A;
  logic [0:127] reg_B;
  logic [0:2]   ctrl_ppp;
  logic [0:1]   ctrl_ww;
  logic [0:4]   alu_op;
  logic [0:127] result;

  modport master (
    output reg_A,
    output reg_B,
    output ctrl_ppp,
    output ctrl_ww,
    output alu_op,
    input  result
  );

  modport slave (
    input  reg_A,
    input  reg_B,
    input  ctrl_ppp,
    input  ctrl_ww,
    input  alu_op,
    output result
  );
endinterface

// File: rtl/alu.sv
// Registered 128-bit lane-parallel SIMD ALU (8/16/32/64-bit lanes, lane masking).
// Optional shifter built only when ALU_SHIFT_EN is defined; otherwise shift opcodes yield 0.
module alu (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  typedef enum logic [4:0] {
    ALUWADD = 5'b00000,
    ALUWSUB = 5'b00001,
    ALUWAND = 5'b00010,
    ALUWOR  = 5'b00011,
    ALUWXOR = 5'b00100,
    ALUWNOT = 5'b00101,
    ALUWMV  = 5'b00110,
    ALUWSLL = 5'b00111,
    ALUWSRL = 5'b01000,
    ALUWSRA = 5'b01001
  } alu_op_e;

  typedef enum logic [2:0] {
    PPP_AA = 3'b000,
    PPP_UU = 3'b001,
    PPP_DD = 3'b010,
    PPP_EE = 3'b011,
    PPP_OO = 3'b100
  } ppp_e;

  // Ports are big-endian ([0:127], bit 0 = MSB); plain assignment keeps the MSB on
  // bit 127 of these descending copies, so lane 0 sits at the top of each vector.
  logic [127:0] a;
  logic [127:0] b;
  logic [4:0]   op;
  logic [2:0]   ppp;
  logic [1:0]   ww;

  assign a   = bus.reg_A;
  assign b   = bus.reg_B;
  assign op  = bus.alu_op;
  assign ppp = bus.ctrl_ppp;
  assign ww  = bus.ctrl_ww;

  // One full-width candidate result and lane mask per lane width; ctrl_ww picks one.
  logic [3:0][127:0] res_w;
  logic [3:0][127:0] mask_w;

  for (genvar gw = 0; gw < 4; gw++) begin : g_width
    localparam int W  = 8 << gw;
    localparam int N  = 128 / W;
`ifdef ALU_SHIFT_EN
    localparam int SW = $clog2(W);
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      localparam int HI = 127 - gi * W;

      logic [W-1:0] la;
      logic [W-1:0] lb;
      logic [W-1:0] lr;
      logic         lane_on;

      assign la = a[HI -: W];
      assign lb = b[HI -: W];

      // Each lane is its own W-bit datapath, so carries and shifted-out bits stay inside it.
      always_comb begin
        lr = '0;
        case (op)
          ALUWADD: lr = la + lb;
          ALUWSUB: lr = la - lb;
          ALUWAND: lr = la & lb;
          ALUWOR:  lr = la | lb;
          ALUWXOR: lr = la ^ lb;
          ALUWNOT: lr = ~la;
          ALUWMV:  lr = la;
`ifdef ALU_SHIFT_EN
          ALUWSLL: lr = la << lb[SW-1:0];
          ALUWSRL: lr = la >> lb[SW-1:0];
          ALUWSRA: lr = $unsigned($signed(la) >>> lb[SW-1:0]);
`endif
          default: lr = '0;
        endcase
      end

      always_comb begin
        lane_on = 1'b0;
        case (ppp)
          PPP_AA:  lane_on = 1'b1;
          PPP_UU:  lane_on = (gi < N / 2);
          PPP_DD:  lane_on = (gi >= N / 2);
          PPP_EE:  lane_on = (gi % 2 == 0);
          PPP_OO:  lane_on = (gi % 2 == 1);
          default: lane_on = 1'b0;
        endcase
      end

      assign res_w[gw][HI -: W]  = lr;
      assign mask_w[gw][HI -: W] = {W{lane_on}};
    end
  end

  logic [127:0] result_next;
  logic [127:0] result_reg;

  assign result_next = res_w[ww] & mask_w[ww];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg <= '0;
    end else begin
      result_reg <= result_next;
    end
  end

  assign bus.result = result_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors, async reset, and randomized
// traffic compared against a lane-by-lane arithmetic reference model.
module tb_alu;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pull each lane out counting from the MSB, do the arithmetic on
  // 64-bit integers masked to the lane width, then place it back.
  function automatic logic [127:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic [2:0] ppp, input logic [1:0] ww,
                                         input logic [4:0] op);
    int w;
    int n;
    int pos;
    int sh;
    bit on;
    longint unsigned m;
    longint unsigned x;
    longint unsigned y;
    longint unsigned r;
    logic [127:0] res;
    w   = 8 << ww;
    n   = 128 / w;
    m   = (w == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int l = 0; l < n; l++) begin
      pos = 128 - (l + 1) * w;
      x   = 64'(a >> pos) & m;
      y   = 64'(b >> pos) & m;
      sh  = int'(y % longint'(w));
      r   = 0;
      case (op)
        5'd0: r = (x + y) & m;
        5'd1: r = (x - y) & m;
        5'd2: r = x & y;
        5'd3: r = x | y;
        5'd4: r = x ^ y;
        5'd5: r = ~x & m;
        5'd6: r = x;
`ifdef ALU_SHIFT_EN
        5'd7: r = (x << sh) & m;
        5'd8: r = x >> sh;
        5'd9: begin
          r = x >> sh;
          if (((x >> (w - 1)) & 64'd1) != 0) r = r | (m & ~(m >> sh));
        end
`endif
        default: r = 0;
      endcase
      case (ppp)
        3'd0:    on = 1'b1;
        3'd1:    on = (l < n / 2);
        3'd2:    on = (l >= n / 2);
        3'd3:    on = (l % 2 == 0);
        3'd4:    on = (l % 2 == 1);
        default: on = 1'b0;
      endcase
      if (on) res = res | ({64'd0, r} << pos);
    end
    return res;
  endfunction

  task automatic drive(input logic [127:0] a, input logic [127:0] b,
                       input logic [2:0] ppp, input logic [1:0] ww, input logic [4:0] op);
    bus.reg_A    = a;
    bus.reg_B    = b;
    bus.ctrl_ppp = ppp;
    bus.ctrl_ww  = ww;
    bus.alu_op   = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    logic [127:0] got;
    reset = 1'b1;
    drive(128'h0102030405060708090a0b0c0d0e0f10, 128'h01020304010203040507070809050607,
          3'd0, 2'd0, 5'd0);
    #2;
    got = bus.result;
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL reset_initial: got %h expected %h", got, 128'h0);
    end
    step();
    step();
    got = bus.result;
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", got, 128'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    $display("reset released, first op result %h", bus.result);
  endtask

  task automatic test_directed();
    logic [127:0] got;
    logic [127:0] exp_v;
    logic [127:0] va [8];
    logic [127:0] vb [8];
    logic [2:0]   vp [8];
    logic [1:0]   vw [8];
    logic [4:0]   vo [8];
    logic [127:0] ve [8];
    va[0] = 128'h0102030405060708090a0b0c0d0e0f10; vb[0] = 128'h01020304010203040507070809050607;
    vp[0] = 3'd0; vw[0] = 2'd0; vo[0] = 5'd0; ve[0] = 128'h0204060806080a0c0e11121416131517;
    va[1] = 128'hfffffffffffffffffffffffffffffff9; vb[1] = 128'h00000000000000000000000000000008;
    vp[1] = 3'd0; vw[1] = 2'd0; vo[1] = 5'd0; ve[1] = 128'hffffffffffffffffffffffffffffff01;
    va[2] = 128'h00010002000300040005000600070008; vb[2] = 128'h0002000400060008000c001000120014;
    vp[2] = 3'd0; vw[2] = 2'd1; vo[2] = 5'd0; ve[2] = 128'h000300060009000c001100160019001c;
    va[3] = 128'h00000001000000020000000300000004; vb[3] = 128'h00000005000000060000000700000008;
    vp[3] = 3'd0; vw[3] = 2'd2; vo[3] = 5'd0; ve[3] = 128'h00000006000000080000000a0000000c;
    va[4] = va[3]; vb[4] = vb[3];
    vp[4] = 3'd1; vw[4] = 2'd2; vo[4] = 5'd0; ve[4] = 128'h00000006000000080000000000000000;
    va[5] = va[0]; vb[5] = vb[0];
    vp[5] = 3'd3; vw[5] = 2'd0; vo[5] = 5'd0; ve[5] = 128'h020006000600_0a00_0e00_1200_1600_1500;
    va[6] = va[0]; vb[6] = vb[0];
    vp[6] = 3'd0; vw[6] = 2'd0; vo[6] = 5'd31; ve[6] = 128'h0;
    va[7] = va[0]; vb[7] = vb[0];
    vp[7] = 3'd5; vw[7] = 2'd0; vo[7] = 5'd0; ve[7] = 128'h0;
    for (int i = 0; i < 8; i++) begin
      drive(va[i], vb[i], vp[i], vw[i], vo[i]);
      step();
      got   = bus.result;
      exp_v = ve[i];
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL directed_%0d: got %h expected %h", i, got, exp_v);
      end else begin
        $display("directed_%0d op=%0d ww=%0d ppp=%0d result %h", i, vo[i], vw[i], vp[i], got);
      end
    end
  endtask

  task automatic test_shift();
    logic [127:0] got;
    logic [127:0] exp_v;
    drive({8{16'h8000}}, {8{16'h0004}}, 3'd0, 2'd1, 5'd9);
    step();
    got = bus.result;
`ifdef ALU_SHIFT_EN
    exp_v = {8{16'hf800}};
`else
    exp_v = 128'h0;
`endif
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL shift_sra_w16: got %h expected %h", got, exp_v);
    end else begin
      $display("shift_sra_w16 result %h", got);
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] got;
    logic [127:0] exp_v;
    drive({16{8'h11}}, {16{8'h22}}, 3'd0, 2'd0, 5'd0);
    step();
    #2;
    reset = 1'b1;
    #1;
    got = bus.result;
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, 128'h0);
    end
    step();
    got = bus.result;
    checks++;
    if (got !== 128'h0) begin
      errors++;
      $display("FAIL async_reset_hold: got %h expected %h", got, 128'h0);
    end
    #2;
    reset = 1'b0;
    drive({4{32'h0000_0100}}, {4{32'h0000_0023}}, 3'd0, 2'd2, 5'd1);
    exp_v = {4{32'h0000_00dd}};
    step();
    got = bus.result;
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL reset_release_first_op: got %h expected %h", got, exp_v);
    end else begin
      $display("reset_release_first_op result %h", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    logic [2:0]   ppp;
    logic [1:0]   ww;
    logic [4:0]   op;
    logic [127:0] got;
    logic [127:0] exp_v;
    for (int i = 0; i < 400; i++) begin
      a   = rand128();
      b   = rand128();
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
      ppp = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      ww  = 2'($urandom_range(0, 3));
      op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
      exp_v = model(a, b, ppp, ww, op);
      drive(a, b, ppp, ww, op);
      step();
      got = bus.result;
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_%0d op=%0d ww=%0d ppp=%0d: got %h expected %h",
                 i, op, ww, ppp, got, exp_v);
      end else begin
        $display("random_%0d op=%0d ww=%0d ppp=%0d result %h", i, op, ww, ppp, got);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_shift();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
